// File: rtl/hazard_pkg.sv
// Shared encodings for the multicore hazard unit.
package hazard_pkg;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [31:0] REG_ZERO = '0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;
endpackage

// File: rtl/hazard_core.sv
// One core's forwarding selects, local hazard/freeze detection, memory wait FSM,
// timeout flag and saturating stall counter.
module hazard_core
  import hazard_pkg::*;
#(
  parameter int REGW = 5,
  parameter int TOUT = 64,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            regwriteE_i,
  input  logic            regwriteM_i,
  input  logic            regwriteW_i,
  input  logic            memtoregE_i,
  input  logic            memtoregM_i,
  input  logic [REGW-1:0] writeregE_i,
  input  logic [REGW-1:0] writeregM_i,
  input  logic [REGW-1:0] writeregW_i,
  input  logic [REGW-1:0] rsD_i,
  input  logic [REGW-1:0] rtD_i,
  input  logic [REGW-1:0] rsE_i,
  input  logic [REGW-1:0] rtE_i,
  input  logic            branchD_i,
  input  logic            jumpD_i,
  input  logic            jalD_i,
  input  logic            jalE_i,
  input  logic            jalM_i,
  input  logic            memreqM_i,
  input  logic            dmem_ready_i,
  input  logic            perf_clr_i,
  input  logic            stallD_i,
  output logic [1:0]      forwardAE_o,
  output logic [1:0]      forwardBE_o,
  output logic            forwardAD_o,
  output logic            forwardBD_o,
  output logic            hz_o,
  output logic            freeze_o,
  output logic            timeout_err_o,
  output logic [CNTW-1:0] stall_cnt_o
);
  localparam int TW = $clog2(TOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TOUT - 1);
  localparam logic [REGW-1:0] RZ = REG_ZERO[REGW-1:0];

  mem_state_e      state_q, state_d;
  logic [TW-1:0]   wcnt_q, wcnt_d;
  logic            terr_q, terr_d;
  logic [CNTW-1:0] scnt_q, scnt_d;
  logic            lwstall, brstall, jstall, jalstall;

  function automatic logic [1:0] fwd_sel(input logic [REGW-1:0] src,
                                         input logic [REGW-1:0] wm, input logic rwm,
                                         input logic [REGW-1:0] ww, input logic rww);
    if (src != RZ && src == wm && rwm)      return FWD_M;
    else if (src != RZ && src == ww && rww) return FWD_W;
    else                                    return FWD_RF;
  endfunction

  assign forwardAE_o = fwd_sel(rsE_i, writeregM_i, regwriteM_i, writeregW_i, regwriteW_i);
  assign forwardBE_o = fwd_sel(rtE_i, writeregM_i, regwriteM_i, writeregW_i, regwriteW_i);
  assign forwardAD_o = (rsD_i != RZ) && (rsD_i == writeregM_i) && regwriteM_i;
  assign forwardBD_o = (rtD_i != RZ) && (rtD_i == writeregM_i) && regwriteM_i;

  assign lwstall  = memtoregE_i && (rtE_i != RZ) && (rsD_i == rtE_i || rtD_i == rtE_i);
  assign brstall  = branchD_i &&
                    ((regwriteE_i && writeregE_i != RZ &&
                      (writeregE_i == rsD_i || writeregE_i == rtD_i)) ||
                     (memtoregM_i && (writeregM_i == rsD_i || writeregM_i == rtD_i)));
  assign jstall   = jumpD_i && !jalD_i;
  assign jalstall = jalE_i || jalM_i;
  assign hz_o     = lwstall || brstall || jstall || jalstall;
  assign freeze_o = memreqM_i && !dmem_ready_i;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    terr_d  = terr_q;
    case (state_q)
      IDLE: if (freeze_o) begin
        state_d = WAIT;
        wcnt_d  = '0;
      end
      WAIT: begin
        if (dmem_ready_i)          state_d = IDLE;
        else if (wcnt_q != TLAST)  wcnt_d  = wcnt_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase
    // Sticky: once a wait has lasted TOUT cycles the flag stays until reset.
    if (state_d == WAIT && wcnt_d == TLAST) terr_d = 1'b1;
  end

  always_comb begin
    scnt_d = scnt_q;
    if (perf_clr_i)                       scnt_d = '0;
    else if (stallD_i && scnt_q != '1)    scnt_d = scnt_q + CNTW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      terr_q  <= 1'b0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      terr_q  <= terr_d;
      scnt_q  <= scnt_d;
    end
  end

  assign timeout_err_o = terr_q;
  assign stall_cnt_o   = scnt_q;
endmodule

// File: rtl/hazard_mc.sv
// N-core hazard unit: per-core hazard logic plus optional lockstep combining of
// hazards and memory freezes across cores.
module hazard_mc
  import hazard_pkg::*;
#(
  parameter int NCORES   = 2,
  parameter int REGW     = 5,
  parameter int LOCKSTEP = 1,
  parameter int TOUT     = 64,
  parameter int CNTW     = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NCORES-1:0]      regwriteE,
  input  logic [NCORES-1:0]      regwriteM,
  input  logic [NCORES-1:0]      regwriteW,
  input  logic [NCORES-1:0]      memtoregE,
  input  logic [NCORES-1:0]      memtoregM,
  input  logic [NCORES*REGW-1:0] writeregE,
  input  logic [NCORES*REGW-1:0] writeregM,
  input  logic [NCORES*REGW-1:0] writeregW,
  input  logic [NCORES*REGW-1:0] rsD,
  input  logic [NCORES*REGW-1:0] rtD,
  input  logic [NCORES*REGW-1:0] rsE,
  input  logic [NCORES*REGW-1:0] rtE,
  input  logic [NCORES-1:0]      branchD,
  input  logic [NCORES-1:0]      jumpD,
  input  logic [NCORES-1:0]      jalD,
  input  logic [NCORES-1:0]      jalE,
  input  logic [NCORES-1:0]      jalM,
  input  logic [NCORES-1:0]      memreqM,
  input  logic [NCORES-1:0]      dmem_ready,
  input  logic                   perf_clr,
  output logic [NCORES*2-1:0]    forwardAE,
  output logic [NCORES*2-1:0]    forwardBE,
  output logic [NCORES-1:0]      forwardAD,
  output logic [NCORES-1:0]      forwardBD,
  output logic [NCORES-1:0]      stallF,
  output logic [NCORES-1:0]      stallD,
  output logic [NCORES-1:0]      stallE,
  output logic [NCORES-1:0]      stallM,
  output logic [NCORES-1:0]      flushE,
  output logic [NCORES-1:0]      timeout_err,
  output logic [NCORES*CNTW-1:0] stall_cnt
);
  logic [NCORES-1:0] hz, frz, any_hz, any_frz;

  for (genvar gi = 0; gi < NCORES; gi++) begin : g_core
    hazard_core #(.REGW(REGW), .TOUT(TOUT), .CNTW(CNTW)) u_core (
      .clk          (clk),
      .reset_n      (reset_n),
      .regwriteE_i  (regwriteE[gi]),
      .regwriteM_i  (regwriteM[gi]),
      .regwriteW_i  (regwriteW[gi]),
      .memtoregE_i  (memtoregE[gi]),
      .memtoregM_i  (memtoregM[gi]),
      .writeregE_i  (writeregE[gi*REGW +: REGW]),
      .writeregM_i  (writeregM[gi*REGW +: REGW]),
      .writeregW_i  (writeregW[gi*REGW +: REGW]),
      .rsD_i        (rsD[gi*REGW +: REGW]),
      .rtD_i        (rtD[gi*REGW +: REGW]),
      .rsE_i        (rsE[gi*REGW +: REGW]),
      .rtE_i        (rtE[gi*REGW +: REGW]),
      .branchD_i    (branchD[gi]),
      .jumpD_i      (jumpD[gi]),
      .jalD_i       (jalD[gi]),
      .jalE_i       (jalE[gi]),
      .jalM_i       (jalM[gi]),
      .memreqM_i    (memreqM[gi]),
      .dmem_ready_i (dmem_ready[gi]),
      .perf_clr_i   (perf_clr),
      .stallD_i     (stallD[gi]),
      .forwardAE_o  (forwardAE[gi*2 +: 2]),
      .forwardBE_o  (forwardBE[gi*2 +: 2]),
      .forwardAD_o  (forwardAD[gi]),
      .forwardBD_o  (forwardBD[gi]),
      .hz_o         (hz[gi]),
      .freeze_o     (frz[gi]),
      .timeout_err_o(timeout_err[gi]),
      .stall_cnt_o  (stall_cnt[gi*CNTW +: CNTW])
    );
  end

  if (LOCKSTEP != 0) begin : g_lockstep
    assign any_hz  = {NCORES{|hz}};
    assign any_frz = {NCORES{|frz}};
  end else begin : g_indep
    assign any_hz  = hz;
    assign any_frz = frz;
  end

  // A frozen pipe holds E, so a hazard must not bubble over the held instruction.
  assign stallF = any_hz | any_frz;
  assign stallD = any_hz | any_frz;
  assign stallE = any_frz;
  assign stallM = any_frz;
  assign flushE = any_hz & ~any_frz;
endmodule

// File: doc/hazard_mc.md
Name: hazard_mc

Overview:
Parametrised N-core hazard unit, successor to the dual-core hazard block in the MIPS multicore pipeline.
- Per core: execute- and decode-stage forwarding selects, load-use/branch/jump/jal stall and flush.
- New over the previous generation: variable-latency data-memory wait FSM with whole-pipe freeze, timeout detection, optional cross-core lockstep stalling, and saturating per-core stall performance counters.
- Sits beside the N datapaths; all hazard inputs arrive as flat per-core vectors (core i in bits [i*W +: W]).

Parameters:
NCORES, 2, number of cores served
REGW, 5, register specifier width
LOCKSTEP, 1, 1 = any core's stall stalls F/D of every core; 0 = cores independent
TOUT, 64, WAIT cycles before timeout_err sets (must be ≥ 1)
CNTW, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
regwriteE/M/W  in  NCORES  register write enables per stage
memtoregE/M  in  NCORES  load in E / M
writeregE/M/W  in  NCORES*REGW  destination register per stage
rsD, rtD, rsE, rtE  in  NCORES*REGW  source specifiers
branchD, jumpD, jalD, jalE, jalM  in  NCORES  control-flow flags
memreqM  in  NCORES  load/store in M
dmem_ready  in  NCORES  data memory completes this cycle
perf_clr  in  1  synchronous clear of all stall counters
forwardAE, forwardBE  out  NCORES*2  00 regfile, 01 from W, 10 from M
forwardAD, forwardBD  out  NCORES  decode forward from M
stallF, stallD, stallE, stallM  out  NCORES  stage holds
flushE  out  NCORES  bubble into E
timeout_err  out  NCORES  sticky memory timeout
stall_cnt  out  NCORES*CNTW  stall cycle counters

Behaviour:
- Forwarding, combinational, per core:
  - forwardAE = 10 if rsE≠0 & rsE==writeregM & regwriteM.
  - Otherwise 01 if rsE≠0 & rsE==writeregW & regwriteW.
  - Otherwise 00. M has priority over W.
  - forwardBE is the same using rtE. forwardAD/BD use rsD/rtD against M.
- Local hazard hz_i, combinational:
  - lwstall = memtoregE & rtE≠0 & (rsD==rtE | rtD==rtE). The rtE≠0 term is a fix over the previous generation.
  - branchstall = branchD & ((regwriteE & writeregE≠0 & writeregE∈{rsD,rtD}) | (memtoregM & writeregM∈{rsD,rtD})).
  - jumpstall = jumpD & ~jalD.
  - jalstall = jalE | jalM.
  - hz_i = OR of the four terms.
- Memory FSM per core, states IDLE/WAIT:
  - freeze_i = memreqM & ~dmem_ready (combinational, either state).
  - IDLE→WAIT when freeze_i. WAIT→IDLE when dmem_ready.
  - Counter: cleared on entry to WAIT; increments each WAIT cycle without ready.
  - When counter reaches TOUT-1, timeout_err_i sets. It clears only on reset. Freeze continues until ready regardless.
- Global terms:
  - If LOCKSTEP=1: anyhz = OR hz, anyfrz = OR freeze.
  - If LOCKSTEP=0: anyhz = hz_i, anyfrz = freeze_i.
- Per-core outputs:
  - stallF = stallD = anyhz | anyfrz.
  - stallE = stallM = anyfrz.
  - flushE = anyhz & ~anyfrz. A frozen pipe is never flushed, so no bubble is inserted over a held instruction.
- stall_cnt_i:
  - Increments by 1 on each cycle where stallD_i=1.
  - Saturates at 2^CNTW-1.
  - perf_clr takes priority and zeroes all counters on the next edge.
- Reset (async, reset_n low):
  - FSMs → IDLE, wait counters 0, timeout_err 0, stall_cnt 0.
  - Combinational outputs follow their inputs.
  - Reset asserted mid-WAIT aborts the wait immediately.
- Simultaneous events:
  - A core that gets dmem_ready on the same cycle as memreqM never enters WAIT and never freezes.
  - Hazard and freeze in the same cycle: freeze wins for flushE; stallF/D are still 1.

Decomposition:
- Package hazard_pkg: forwarding encodings FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10; FSM state enum {IDLE, WAIT}; REG_ZERO constant.
- Sub-module hazard_core: one core's forwarding, hz and freeze logic, memory FSM, timeout counter and stall counter.
- The top level generates NCORES instances and performs the lockstep OR-reduction.

Test Plan:
- Core0 add writes r8, next instruction reads r8 in E (rsE=8, writeregM=8, regwriteM=1); same reg also in W → forwardAE[1:0]=10. Remove M match → 01. writeregM=0 with rsE=0 → 00.
- Core1 lw r9 in E (memtoregE=1, rtE=9), rsD=9, LOCKSTEP=1 → stallF=stallD=flushE=2'b11, stallE=0, both counters +1. Repeat with rtE=0 → no stall.
- Core0 memreqM=1, dmem_ready low for 3 cycles → stallF/D/E/M=1 and flushE=0 on both cores for 3 cycles; release on ready; core0 stall_cnt=3.
- TOUT=4, ready held low for 6 cycles → timeout_err[0]=1 from cycle 4. Stays 1 after ready. Clears only when reset_n is pulsed low mid-WAIT, and the FSM is IDLE on release.
- LOCKSTEP=0, core1 jumpD=1, jalD=0 → core1 stallF/flushE=1; core0 outputs all 0.
- Drive stallD continuously for 2^CNTW+5 cycles → counter holds all-ones. Pulse perf_clr → 0 next cycle, then resumes counting.
